// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding and default
// timing constants for an 868-clock-per-baud UART.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2
    } arb_state_e;

    localparam int CLOCKS_PER_BAUD = 868;
    localparam int HALF_PER_BAUD   = 434;
    // Ten bit-times: one full UART frame of silence mid-packet.
    localparam int TIMEOUT_CYCLES  = 8680;

endpackage : uart_arb_pkg

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: the first valid requester strictly after
// last_grant, found by rotating a doubled request vector and priority-encoding.
module uart_rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] valid_i,
    input  logic [IDX_W-1:0] last_grant_i,
    output logic [IDX_W-1:0] pick_idx_o,
    output logic             any_valid_o
);

    logic [2*N_REQ-1:0] dbl_s;
    logic [2*N_REQ-1:0] rot_s;
    logic [IDX_W:0]     start_s;
    logic [IDX_W:0]     off_s;
    logic [IDX_W:0]     sum_s;

    // Rotate so the scan start sits at bit 0, then take the lowest set bit.
    always_comb begin
        dbl_s = {valid_i, valid_i};
        if (last_grant_i >= IDX_W'(N_REQ - 1)) begin
            start_s = {(IDX_W+1){1'b0}};
        end else begin
            start_s = {1'b0, last_grant_i} + (IDX_W+1)'(1);
        end
        rot_s = dbl_s >> start_s;
        off_s = {(IDX_W+1){1'b0}};
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot_s[k]) begin
                off_s = (IDX_W+1)'(k);
            end else begin
                off_s = off_s;
            end
        end
        sum_s = start_s + off_s;
        if (sum_s >= (IDX_W+1)'(N_REQ)) begin
            pick_idx_o = IDX_W'(sum_s - (IDX_W+1)'(N_REQ));
        end else begin
            pick_idx_o = sum_s[IDX_W-1:0];
        end
        any_valid_o = |valid_i;
    end

endmodule : uart_rr_pick

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter sharing one UART TX byte port between
// N_REQ requesters, with a stall timeout that drops a wedged packet.
module uart_tx_arbiter #(
    parameter int N_REQ          = 4,
    parameter int IDX_W          = 2,
    parameter int DW             = 8,
    parameter int TO_BITS        = 14,
    parameter int TIMEOUT_CYCLES = uart_arb_pkg::TIMEOUT_CYCLES
) (
    input  logic                clk,
    input  logic                i_reset,
    input  logic [N_REQ-1:0]    i_req_valid,
    input  logic [N_REQ*DW-1:0] i_req_data,
    input  logic [N_REQ-1:0]    i_req_last,
    output logic [N_REQ-1:0]    o_req_ready,
    output logic                o_tx_valid,
    output logic [DW-1:0]       o_tx_data,
    input  logic                i_tx_ready,
    output logic                o_grant_valid,
    output logic [IDX_W-1:0]    o_grant_idx,
    output logic                o_abort
);

    import uart_arb_pkg::*;

    arb_state_e         state_q, state_d;
    logic [IDX_W-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]   last_grant_q, last_grant_d;
    logic               grant_valid_q, grant_valid_d;
    logic               first_byte_q, first_byte_d;
    logic               last_q, last_d;
    logic [TO_BITS-1:0] to_cnt_q, to_cnt_d;
    logic [DW-1:0]      tx_data_q, tx_data_d;
    logic               tx_valid_q, tx_valid_d;
    logic [N_REQ-1:0]   req_ready_q, req_ready_d;
    logic               abort_q, abort_d;

    logic [IDX_W-1:0]   pick_idx_s;
    logic               any_valid_s;
    logic [N_REQ-1:0]   grant_onehot_s;

    uart_rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .valid_i      (i_req_valid),
        .last_grant_i (last_grant_q),
        .pick_idx_o   (pick_idx_s),
        .any_valid_o  (any_valid_s)
    );

    // Next-state logic; ready and tx_valid are derived from the next state so
    // they come straight out of flops with no path from i_req_valid.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_grant_d  = last_grant_q;
        grant_valid_d = grant_valid_q;
        first_byte_d  = first_byte_q;
        last_d        = last_q;
        to_cnt_d      = to_cnt_q;
        tx_data_d     = tx_data_q;
        abort_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (any_valid_s) begin
                    grant_d       = pick_idx_s;
                    grant_valid_d = 1'b1;
                    first_byte_d  = 1'b1;
                    to_cnt_d      = {TO_BITS{1'b0}};
                    state_d       = LOAD;
                end else begin
                    state_d       = IDLE;
                end
            end
            LOAD: begin
                if (i_req_valid[grant_q]) begin
                    tx_data_d    = i_req_data[int'(grant_q)*DW +: DW];
                    last_d       = i_req_last[grant_q];
                    first_byte_d = 1'b0;
                    to_cnt_d     = {TO_BITS{1'b0}};
                    state_d      = SEND;
                end else if (!first_byte_q) begin
                    // Mid-packet stall: give up after TIMEOUT_CYCLES idle cycles.
                    if (to_cnt_q >= TO_BITS'(TIMEOUT_CYCLES - 1)) begin
                        abort_d       = 1'b1;
                        last_grant_d  = grant_q;
                        grant_valid_d = 1'b0;
                        to_cnt_d      = {TO_BITS{1'b0}};
                        state_d       = IDLE;
                    end else begin
                        to_cnt_d      = to_cnt_q + TO_BITS'(1);
                    end
                end else begin
                    to_cnt_d = to_cnt_q;
                end
            end
            SEND: begin
                if (i_tx_ready) begin
                    if (last_q) begin
                        last_grant_d  = grant_q;
                        grant_valid_d = 1'b0;
                        state_d       = IDLE;
                    end else begin
                        state_d       = LOAD;
                    end
                end else begin
                    state_d = SEND;
                end
            end
            default: begin
                grant_valid_d = 1'b0;
                state_d       = IDLE;
            end
        endcase

        grant_onehot_s = {{(N_REQ-1){1'b0}}, 1'b1} << grant_d;
        if (state_d == LOAD) begin
            req_ready_d = grant_onehot_s;
        end else begin
            req_ready_d = {N_REQ{1'b0}};
        end
        tx_valid_d = (state_d == SEND);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            state_q       <= IDLE;
            grant_q       <= {IDX_W{1'b0}};
            last_grant_q  <= IDX_W'(N_REQ - 1);
            grant_valid_q <= 1'b0;
            first_byte_q  <= 1'b0;
            last_q        <= 1'b0;
            to_cnt_q      <= {TO_BITS{1'b0}};
            tx_data_q     <= {DW{1'b0}};
            tx_valid_q    <= 1'b0;
            req_ready_q   <= {N_REQ{1'b0}};
            abort_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_grant_q  <= last_grant_d;
            grant_valid_q <= grant_valid_d;
            first_byte_q  <= first_byte_d;
            last_q        <= last_d;
            to_cnt_q      <= to_cnt_d;
            tx_data_q     <= tx_data_d;
            tx_valid_q    <= tx_valid_d;
            req_ready_q   <= req_ready_d;
            abort_q       <= abort_d;
        end
    end

    assign o_req_ready   = req_ready_q;
    assign o_tx_valid    = tx_valid_q;
    assign o_tx_data     = tx_data_q;
    assign o_grant_valid = grant_valid_q;
    assign o_grant_idx   = grant_q;
    assign o_abort       = abort_q;

endmodule : uart_tx_arbiter

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one UART transmitter between N_REQ byte-stream requesters, for example an echo path, a status reporter and a debug dumper. Grants are round-robin and packet-locked: once granted, a requester keeps the transmitter until it delivers a byte flagged last, or until it stalls past a timeout. The block sits between the requesters and the UART TX byte interface, which uses a valid/ready handshake.

Parameters:
N_REQ, 4, number of requesters (2..8)
IDX_W, 2, width of the grant index; must satisfy 2**IDX_W >= N_REQ
DW, 8, data byte width
TO_BITS, 14, width of the stall timeout counter
TIMEOUT_CYCLES, 8680, maximum mid-packet stall in clk cycles (10 bit-times at 868 clocks per baud)

Ports:
clk  in  1  system clock; all logic on the rising edge
i_reset  in  1  synchronous, active-high reset
i_req_valid  in  N_REQ  per-requester byte valid
i_req_data  in  N_REQ*DW  packed bytes; requester k occupies bits [k*DW +: DW]
i_req_last  in  N_REQ  byte is the final byte of the packet
o_req_ready  out  N_REQ  one-hot ready; a byte transfers when valid and ready are both high
o_tx_valid  out  1  byte available to the UART TX
o_tx_data  out  DW  byte for the UART TX
i_tx_ready  in  1  UART TX accepts the byte this cycle
o_grant_valid  out  1  a requester currently owns the transmitter
o_grant_idx  out  IDX_W  index of the owning requester
o_abort  out  1  one-cycle pulse when a packet is dropped on timeout

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high on i_reset.
- Reset state:
  - state=IDLE, o_req_ready=0, o_tx_valid=0, o_tx_data=0, o_grant_valid=0, o_grant_idx=0, o_abort=0.
  - last_grant=N_REQ-1, so requester 0 has first priority.
  - Timeout counter=0, first_byte flag=0.
- Reset mid-packet: the packet is abandoned and o_tx_valid drops the next cycle. No abort pulse is generated.
- State IDLE:
  - If any i_req_valid is high, pick the first valid index scanning from (last_grant+1) mod N_REQ upward, wrapping around.
  - Register the pick into grant; set o_grant_valid=1 and first_byte=1; go to LOAD.
  - If no i_req_valid is high, stay in IDLE.
- State LOAD:
  - o_req_ready[grant]=1; all other ready bits are 0. Ready is decoded from registered state only, with no combinational path from i_req_valid.
  - On i_req_valid[grant]: capture the byte into o_tx_data and the last flag internally; clear first_byte and the timeout counter; go to SEND.
  - If valid is low and first_byte=0: increment the timeout counter.
  - When the counter reaches TIMEOUT_CYCLES-1 with valid still low:
    - pulse o_abort;
    - set last_grant=grant and o_grant_valid=0;
    - go to IDLE.
  - If valid is low and first_byte=1, no timeout applies. Requesters must hold valid until ready; this is a protocol rule, not checked.
- State SEND:
  - o_tx_valid=1 and o_tx_data are held stable until i_tx_ready.
  - On i_tx_ready with last set: last_grant=grant, o_grant_valid=0, go to IDLE.
  - On i_tx_ready without last: go to LOAD.
- Latency:
  - Requester valid in IDLE at cycle t gives ready at t+1, and o_tx_valid at t+2 if valid holds.
  - TX accept at cycle t gives ready again at t+1 (mid-packet), or a new grant decision at t+1 (IDLE).
- Throughput: at most 1 byte per 2 cycles. This is far above the UART rate and acceptable.
- Simultaneous events:
  - A requester asserting valid while another requester owns the grant waits; it is never preempted mid-packet.
  - o_abort cannot coincide with a byte transfer.
- Wrap-around: when last_grant=N_REQ-1, the scan starts at index 0.
- Single requester: the same requester is regranted immediately after its packet ends.
- Width rule: the timeout counter saturates at TIMEOUT_CYCLES-1, with TIMEOUT_CYCLES < 2**TO_BITS.
- o_tx_data retains its last byte outside SEND. Consumers must qualify it with o_tx_valid.

Decomposition:
- Package uart_arb_pkg:
  - state encoding IDLE/LOAD/SEND (2 bits);
  - default constants CLOCKS_PER_BAUD=868, HALF_PER_BAUD=434, TIMEOUT_CYCLES=8680.
- One sub-module, uart_rr_pick: combinational round-robin picker.
  - Inputs: valid vector, last_grant.
  - Outputs: pick index, any_valid.
  - Implemented as a double-width rotate and priority encode.

Test Plan:
- Reset, then requester 0 sends 0x41,0x42(last) with i_tx_ready=1 -> ready[0] at t+1, o_tx_valid with 0x41 at t+2, then 0x42; o_grant_valid falls after the 0x42 accept; last_grant=0.
- All four requesters valid with single-byte last packets, i_tx_ready=1 -> grant order 0,1,2,3,0; no requester granted twice in a row while others wait.
- Requester 2 mid-packet (sent 0x10, not last), requester 1 valid -> requester 1 is not granted until requester 2 sends its last byte; grant then goes to 3 if valid, otherwise wraps to 0, then 1.
- Requester 1 sends 0x55 (not last) then drops valid -> o_abort pulses exactly TIMEOUT_CYCLES cycles after re-entering LOAD; state IDLE; next grant starts at index 2.
- i_tx_ready held low for 1000 cycles during SEND -> o_tx_valid and o_tx_data=0xA5 stay constant; no timeout or abort; byte transfers on the first ready.
- i_reset asserted in SEND -> next cycle o_tx_valid=0, o_req_ready=0, o_grant_valid=0; after release requester 0 wins a tie with requester 3.
